clock_tick_gen: RTL
===================

// Module: clock_tick_gen
// PURPOSE
//   Multi-channel programmable clock/tick generator driven by the 50 MHz board clock.
//   Each channel divides the input clock by a runtime-loadable divisor.
//   Each channel outputs a one-cycle tick strobe and a near-50%-duty square wave.
//   Feeds counters, display scanners and debouncers, which use the ticks as clock enables.
//   The block adds per-channel enable, glitch-free divisor reload and global phase sync.
// PARAMETERS
//   CLK_HZ       50_000_000  input clock frequency in Hz
//   CHANNELS     4           number of independent output channels (1..16)
//   CNT_W        32          divisor/counter width in bits
//   DEFAULT_HZ   1           reset output frequency of every channel; DEFAULT_DIV = CLK_HZ/DEFAULT_HZ
// PORTS
//   i_clock_50mhz  in   1               system clock
//   i_reset        in   1               asynchronous reset, active low
//   i_enable       in   CHANNELS        per-channel run enable, level
//   i_sync         in   1               synchronous restart of all channel phases, 1-cycle pulse
//   i_load         in   1               divisor write strobe
//   i_load_ch      in   $clog2(CHANNELS) target channel of the write (use width 1 when CHANNELS=1)
//   i_load_div     in   CNT_W           new divisor value
//   o_tick         out  CHANNELS        one-cycle strobe, once per period
//   o_clk          out  CHANNELS        divided square wave
//   o_pending      out  CHANNELS        a written divisor is waiting for the next wrap
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - cnt = 0, div = shadow = DEFAULT_DIV
//     - o_tick = 0, o_clk = 0, o_pending = 0
//   Per-channel state:
//     - cnt[CNT_W], active divisor div, shadow divisor shd
//   Running (i_enable[c] = 1, div >= 1):
//     - cnt counts 0..div-1 and then wraps to 0
//     - Period is exactly div clocks
//     - o_tick[c] is registered: it is 1 in the cycle after cnt == div-1
//     - o_clk[c] is registered: it is 1 while the registered count is < div>>1
//     - Even div gives 50% duty; odd div gives a low phase one cycle longer
//     - div = 1: o_tick is held 1 and o_clk is held 0
//   div = 0:
//     - The channel is halted: cnt is held at 0, o_tick = 0, o_clk = 0
//   Disabled (i_enable[c] = 0):
//     - cnt is held at 0 and o_tick = 0 from the next cycle
//     - o_clk = 0 from the next cycle
//     - Re-enable starts at cnt = 0 with no extra tick
//   Divisor load (i_load = 1):
//     - shd[i_load_ch] <= i_load_div
//     - Channel disabled or halted: div <= i_load_div in the same cycle, o_pending stays 0
//     - Channel running: o_pending[c] <= 1; on the next wrap, div <= shd and o_pending <= 0
//     - A running period is never truncated or stretched by a load
//   Simultaneous load and wrap on the same channel:
//     - The written value is bypassed into div at this wrap, o_pending stays 0
//   Two loads before a wrap: the last value wins.
//   i_load_ch >= CHANNELS: the write is ignored.
//   i_sync = 1:
//     - Every enabled channel gets cnt <= 0, with no tick from that cycle
//     - Pending divisors are committed (div <= shd, o_pending <= 0)
//     - i_sync has priority over a wrap in the same cycle
//   Arithmetic: the counter compare is unsigned CNT_W-bit; the counter never exceeds div-1.
//   Reset mid-period: all outputs drop immediately (async) and pending loads are discarded.
//   Latency: input changes are visible on the outputs one clock later. No combinational input->output paths.
// TESTING
//   1. Reset release, CLK_HZ=50, DEFAULT_HZ=5 (div=10):
//      -> o_tick pulses every 10 clocks
//      -> o_clk is high 5 clocks, low 5 clocks
//   2. Load div=4 at cnt=3 of a div=10 period:
//      -> o_pending=1 until the wrap
//      -> the current period stays 10 clocks, subsequent periods are 4 clocks
//   3. Load issued in the exact wrap cycle:
//      -> the next period already uses the new value, o_pending never asserts
//   4. Divisor boundaries:
//      -> div=1 holds o_tick=1 and o_clk=0
//      -> div=0 halts the channel
//      -> div=3 gives o_clk high 1 clock, low 2 clocks
//   5. Enable and sync:
//      -> de-assert i_enable[1] mid-period: o_clk[1] and o_tick[1] are 0 next cycle
//      -> re-enable: first tick arrives exactly div clocks later
//      -> i_sync aligns channels 0 and 2 so their ticks coincide
//   6. Assert i_reset mid-period with a load pending:
//      -> outputs clear asynchronously, div returns to DEFAULT_DIV, o_pending = 0

Source files
------------

// File: rtl/clock_tick_gen.sv
// Multi-channel programmable clock divider: per-channel tick strobe and square wave,
// with run enable, divisor reload deferred to the period boundary, and global phase sync.
module clock_tick_gen #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned DEFAULT_HZ = 1,
    localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clock_50mhz,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_enable,
    input  logic                i_sync,
    input  logic                i_load,
    input  logic [CH_W-1:0]     i_load_ch,
    input  logic [CNT_W-1:0]    i_load_div,
    output logic [CHANNELS-1:0] o_tick,
    output logic [CHANNELS-1:0] o_clk,
    output logic [CHANNELS-1:0] o_pending
);

    localparam logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(CLK_HZ / DEFAULT_HZ);

    // High-phase length; odd divisors round down so the low phase is the longer one.
    function automatic logic [CNT_W-1:0] half_div(input logic [CNT_W-1:0] d);
        return d >> 1;
    endfunction

    function automatic logic is_last(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] d);
        return cnt == (d - CNT_W'(1));
    endfunction

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_p1, div_p1, shd_p1;
        logic             pend_p1, tick_p1, clk_p1;
        logic [CNT_W-1:0] cnt_p0, div_p0, shd_p0;
        logic             pend_p0, tick_p0, clk_p0;
        logic             run, wrap, hit;

        // Stage p0: next-state decision from current state and this cycle's controls
        always_comb begin
            run     = i_enable[c] && (div_p1 != '0);
            wrap    = run && is_last(cnt_p1, div_p1);
            hit     = i_load && (i_load_ch == CH_W'(c));
            shd_p0  = hit ? i_load_div : shd_p1;
            cnt_p0  = cnt_p1;
            div_p0  = div_p1;
            pend_p0 = pend_p1;
            tick_p0 = 1'b0;
            if (!run) begin
                // Idle channel: nothing to protect, so writes take effect at once.
                cnt_p0  = '0;
                div_p0  = shd_p0;
                pend_p0 = 1'b0;
            end else if (i_sync) begin
                cnt_p0  = '0;
                div_p0  = shd_p0;
                pend_p0 = 1'b0;
            end else if (wrap) begin
                cnt_p0  = '0;
                div_p0  = shd_p0;
                pend_p0 = 1'b0;
                tick_p0 = 1'b1;
            end else begin
                cnt_p0  = cnt_p1 + CNT_W'(1);
                pend_p0 = pend_p1 | hit;
            end
            clk_p0 = run && (cnt_p0 < half_div(div_p0));
        end

        // Stage p1: channel state and registered outputs
        always_ff @(posedge i_clock_50mhz or negedge i_reset) begin
            if (!i_reset) begin
                cnt_p1  <= '0;
                div_p1  <= DEFAULT_DIV;
                shd_p1  <= DEFAULT_DIV;
                pend_p1 <= 1'b0;
                tick_p1 <= 1'b0;
                clk_p1  <= 1'b0;
            end else begin
                cnt_p1  <= cnt_p0;
                div_p1  <= div_p0;
                shd_p1  <= shd_p0;
                pend_p1 <= pend_p0;
                tick_p1 <= tick_p0;
                clk_p1  <= clk_p0;
            end
        end

        assign o_tick[c]    = tick_p1;
        assign o_clk[c]     = clk_p1;
        assign o_pending[c] = pend_p1;
    end

endmodule
